// File: rtl/gcd_driver_if.sv
// Upstream request bus between the front-end controller and gcd_driver.
// The controller drives start/op_a/op_b and sees the handshake and result.
interface gcd_driver_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             timeout;
    logic [7:0]       op_count;

    modport master (
        output start, op_a, op_b,
        input  busy, result_valid, result, timeout, op_count
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, result_valid, result, timeout, op_count
    );
endinterface

// File: rtl/gcd_driver.sv
// Request-side sequencer for the gcd engine: load strobe, settle window, result capture.
// Optional WAIT timeout is enabled by defining GCD_DRV_TIMEOUT_EN.
module gcd_driver #(
    parameter int WIDTH         = 5,
    parameter int LOAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
`ifdef GCD_DRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 63
`endif
) (
    input  logic             clk,
    input  logic             reset,
    gcd_driver_if.slave      req,
    output logic             load_n,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_done
);

    localparam int MAX_PHASE = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W     = (MAX_PHASE < 2) ? 1 : $clog2(MAX_PHASE + 1);

`ifdef GCD_DRV_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] waitCnt;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phaseCnt;

    // The settle window masks gcd_done because the engine's stale minimum can flag a false done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            phaseCnt         <= '0;
            load_n           <= 1'b1;
            a_out            <= '0;
            b_out            <= '0;
            req.busy         <= 1'b0;
            req.result_valid <= 1'b0;
            req.result       <= '0;
            req.timeout      <= 1'b0;
            req.op_count     <= 8'd0;
`ifdef GCD_DRV_TIMEOUT_EN
            waitCnt          <= '0;
`endif
        end else begin
            req.result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.start) begin
                        a_out    <= req.op_a;
                        b_out    <= req.op_b;
                        load_n   <= 1'b0;
                        req.busy <= 1'b1;
                        phaseCnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (phaseCnt == CNT_W'(LOAD_CYCLES - 1)) begin
                        load_n   <= 1'b1;
                        phaseCnt <= '0;
`ifdef GCD_DRV_TIMEOUT_EN
                        waitCnt  <= '0;
`endif
                        state    <= (SETTLE_CYCLES == 0) ? S_WAIT : S_SETTLE;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (phaseCnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        phaseCnt <= '0;
`ifdef GCD_DRV_TIMEOUT_EN
                        waitCnt  <= '0;
`endif
                        state    <= S_WAIT;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        req.result       <= gcd_result;
                        req.timeout      <= 1'b0;
                        req.result_valid <= 1'b1;
                        req.op_count     <= req.op_count + 8'd1;
                        state            <= S_DONE;
                    end
`ifdef GCD_DRV_TIMEOUT_EN
                    // Abandon the request after TIMEOUT samples of WAIT without done.
                    else if (waitCnt == TO_W'(TIMEOUT - 1)) begin
                        req.result       <= '0;
                        req.timeout      <= 1'b1;
                        req.result_valid <= 1'b1;
                        req.op_count     <= req.op_count + 8'd1;
                        state            <= S_DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    req.busy    <= 1'b0;
                    req.timeout <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
